// File: rtl/raybox_pkg.sv
// raybox_pkg: screen geometry, field widths and trace-writer types shared across the renderer
package raybox_pkg;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int HALF_HEIGHT   = 240;
    localparam int COL_W         = 10;
    localparam int HGT_W         = 8;
    localparam int RAW_HGT_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } wr_state_t;

    typedef struct packed {
        logic [COL_W-1:0]     column;
        logic [RAW_HGT_W-1:0] height;
        logic                 side;
    } trace_entry_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: small power-of-two FIFO with synchronous flush, head word always visible on rdata
module trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // The extra pointer bit distinguishes full from empty when the index bits coincide
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Storage write; the caller never pushes while full
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Pointer update; flush and reset both empty the queue, wrap is implicit in the width
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/trace_writer.sv
// trace_writer: buffers tracer results and writes in-order columns into the trace buffer during blanking
import raybox_pkg::*;

module trace_writer #(
    parameter int COLUMNS    = SCREEN_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int HEIGHT_MAX = HALF_HEIGHT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COL_W-1:0]     in_column,
    input  logic [RAW_HGT_W-1:0] in_height,
    input  logic                 in_side,
    input  logic                 bus_free,
    output logic                 buf_cs,
    output logic                 buf_we,
    output logic [COL_W-1:0]     buf_column,
    output logic [HGT_W-1:0]     buf_height,
    output logic                 buf_side,
    output logic                 frame_done,
    output logic                 col_err
);
    localparam logic [RAW_HGT_W-1:0] HMAX     = RAW_HGT_W'(HEIGHT_MAX);
    localparam logic [COL_W-1:0]     LAST_COL = COL_W'(COLUMNS - 1);

    wr_state_t        state;
    logic [COL_W-1:0] expected;
    trace_entry_t     head;
    logic             full;
    logic             empty;
    logic             fill;
    logic             push;
    logic             pop;
    logic             hit;
    logic             last;

    // Handshake and pop decisions; frame_start blocks both so the flush sees a quiet queue
    always_comb begin
        fill     = state == ST_FILL;
        in_ready = reset_n && fill && !full && !frame_start;
        push     = in_valid && in_ready;
        pop      = reset_n && fill && !empty && bus_free && !frame_start;
        hit      = pop && head.column == expected;
        last     = hit && expected == LAST_COL;
    end

    // Write port is driven only on a matching pop, otherwise held at zero
    always_comb begin
        buf_cs     = hit;
        buf_we     = hit;
        buf_column = hit ? head.column : '0;
        buf_height = hit ? HGT_W'(head.height > HMAX ? HMAX : head.height) : '0;
        buf_side   = hit ? head.side : 1'b0;
    end

    trace_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(trace_entry_t))
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (frame_start),
        .push   (push),
        .pop    (pop),
        .wdata  ({in_column, in_height, in_side}),
        .rdata  (head),
        .full   (full),
        .empty  (empty)
    );

    // Frame FSM with expected-column counter, sticky order error and done pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            expected   <= '0;
            col_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last;
            if (frame_start) begin
                state    <= ST_FILL;
                expected <= '0;
                col_err  <= 1'b0;
            end else if (pop) begin
                if (hit) begin
                    expected <= expected + 1'b1;
                    if (last) state <= ST_DONE;
                end else begin
                    col_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_trace_writer.sv
// tb_trace_writer: directed stimulus against a queue-based model of the trace writer
module tb_trace_writer;
    localparam int COLUMNS = 640;
    localparam int DEPTH   = 4;
    localparam int HMAX    = 240;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_column = '0;
    logic [9:0] in_height = '0;
    logic       in_side = 1'b0;
    logic       bus_free = 1'b0;
    logic       buf_cs;
    logic       buf_we;
    logic [9:0] buf_column;
    logic [7:0] buf_height;
    logic       buf_side;
    logic       frame_done;
    logic       col_err;

    trace_writer #(.COLUMNS(COLUMNS), .FIFO_DEPTH(DEPTH), .HEIGHT_MAX(HMAX)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_column(in_column),
        .in_height(in_height), .in_side(in_side), .bus_free(bus_free),
        .buf_cs(buf_cs), .buf_we(buf_we), .buf_column(buf_column),
        .buf_height(buf_height), .buf_side(buf_side),
        .frame_done(frame_done), .col_err(col_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int h;
        int s;
    } ent_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_count = 0;
    int done_count = 0;
    int last_col = -1;
    int last_h = -1;

    ent_t q[$];
    bit   m_filling = 0;
    int   m_next = 0;
    bit   m_err = 0;
    bit   m_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Model: the writer accepts while filling with room, writes the queue head when it is the next column
    always @(negedge clk) begin
        bit   rdy;
        bit   pop;
        bit   wr;
        ent_t e;
        rdy = reset_n && m_filling && q.size() < DEPTH && !frame_start;
        pop = reset_n && m_filling && q.size() > 0 && bus_free && !frame_start;
        wr  = pop && q[0].c == m_next;
        if (cyc > 0) begin
            chk("in_ready", int'(in_ready), int'(rdy));
            chk("buf_we", int'(buf_we), int'(wr));
            chk("buf_cs", int'(buf_cs), int'(wr));
            chk("buf_column", int'(buf_column), wr ? q[0].c : 0);
            chk("buf_height", int'(buf_height), wr ? (q[0].h > HMAX ? HMAX : q[0].h) : 0);
            chk("buf_side", int'(buf_side), wr ? q[0].s : 0);
            chk("frame_done", int'(frame_done), int'(m_done));
            chk("col_err", int'(col_err), int'(m_err));
            if (buf_we) begin
                wr_count++;
                last_col = int'(buf_column);
                last_h = int'(buf_height);
            end
            if (frame_done) done_count++;
        end
        if (!reset_n) begin
            q.delete();
            m_filling = 0;
            m_next = 0;
            m_err = 0;
            m_done = 0;
        end else begin
            m_done = wr && m_next == COLUMNS - 1;
            if (frame_start) begin
                q.delete();
                m_filling = 1;
                m_next = 0;
                m_err = 0;
            end else begin
                if (pop) begin
                    e = q.pop_front();
                    if (wr) begin
                        if (m_next == COLUMNS - 1) m_filling = 0;
                        m_next++;
                    end else begin
                        m_err = 1;
                    end
                end
                if (in_valid && rdy) q.push_back('{c: int'(in_column), h: int'(in_height), s: int'(in_side)});
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic send(input int c, input int h, input int s);
        bit got = 0;
        in_valid = 1'b1;
        in_column = 10'(c);
        in_height = 10'(h);
        in_side = 1'(s);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    initial begin
        int acc;
        int base;
        // reset and idle
        step(2);
        reset_n = 1'b1;
        in_valid = 1'b1;
        step(2);
        @(negedge clk);
        chk("idle_ready", int'(in_ready), 0);
        chk("idle_we", int'(buf_we), 0);
        chk("idle_done", int'(frame_done), 0);
        step();
        in_valid = 1'b0;

        // full frame, bus always free
        bus_free = 1'b1;
        pulse_start();
        base = wr_count;
        for (int c = 0; c < COLUMNS; c++) send(c, (c * 7) % 600, c % 2);
        step(4);
        chk("frame_writes", wr_count - base, COLUMNS);
        chk("frame_last_col", last_col, COLUMNS - 1);
        chk("frame_done_count", done_count, 1);
        in_valid = 1'b1;
        @(negedge clk);
        chk("done_ready", int'(in_ready), 0);
        step();
        in_valid = 1'b0;

        // backpressure: four accepts then stall
        pulse_start();
        bus_free = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_column = 10'(acc);
            in_height = 10'(100 + acc);
            @(negedge clk);
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_accepts", acc, 4);
        base = wr_count;
        bus_free = 1'b1;
        step(4);
        chk("bp_drain", wr_count - base, 4);
        send(4, 104, 1);
        step(2);
        chk("bp_fifth", last_col, 4);

        // clamp boundaries and an out-of-order column
        pulse_start();
        send(0, 300, 1);
        step();
        chk("clamp_300", last_h, 240);
        send(5, 10, 0);
        step();
        chk("err_set", int'(col_err), 1);
        send(1, 240, 0);
        step();
        chk("after_err_col", last_col, 1);
        send(2, 241, 1);
        send(3, 239, 0);
        send(4, 1023, 1);
        step();
        chk("clamp_1023", last_h, 240);

        // abort with three queued entries
        bus_free = 1'b0;
        send(5, 1, 0);
        send(6, 2, 0);
        send(7, 3, 0);
        in_valid = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        chk("abort_ready", int'(in_ready), 0);
        step();
        frame_start = 1'b0;
        in_valid = 1'b0;
        bus_free = 1'b1;
        step(2);
        chk("abort_err_clear", int'(col_err), 0);
        send(0, 50, 1);
        step();
        chk("abort_next_col", last_col, 0);

        // reset mid-fill overrides frame_start and drops queued words
        bus_free = 1'b0;
        send(1, 20, 0);
        send(2, 30, 1);
        base = wr_count;
        bus_free = 1'b1;
        reset_n = 1'b0;
        frame_start = 1'b1;
        step(2);
        frame_start = 1'b0;
        reset_n = 1'b1;
        step(4);
        chk("reset_no_writes", wr_count - base, 0);
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
